// File: rtl/dcache_wb_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dcache_wb_buffer_pkg
//   Shared DCache write-back buffer definitions: the line-address type, the
//   buffered entry record, the drain FSM states and the fixed AXI burst fields.
// -----------------------------------------------------------------------------
package dcache_wb_buffer_pkg;

  // Line address: byte address bits [31:4]; the 16-byte offset is dropped.
  typedef logic [27:0] DCLineAddr_t;

  typedef struct packed {
    logic        valid;
    DCLineAddr_t addr;
    logic [127:0] data;
  } DCWbEntry_t;

  typedef enum logic [1:0] {IDLE, AW, W, B} DCWbState_t;

  localparam logic [7:0] DC_WB_AWLEN    = 8'd3;    // 4 beats
  localparam logic [2:0] DC_WB_AWSIZE   = 3'b010;  // 4 bytes per beat
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/dcache_wb_buffer_match.sv
// -----------------------------------------------------------------------------
// dc_wb_match
//   DEPTH-way line-address comparator for the write-back buffer. Flags a
//   refill address that is still held in a valid entry and, when
//   DC_WB_FORWARD_EN is defined, selects the youngest matching entry's data.
//
// Ports
//   i_valid    : per-entry valid bits
//   i_addr     : per-entry line addresses
//   i_chk_line : refill line address to check
//   o_conflict : some valid entry holds i_chk_line
//   i_head     : (DC_WB_FORWARD_EN) index of the oldest entry
//   i_data     : (DC_WB_FORWARD_EN) per-entry line data
//   o_data     : (DC_WB_FORWARD_EN) youngest matching entry's data, 0 if none
// -----------------------------------------------------------------------------
module dc_wb_match
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  DCLineAddr_t              i_addr [DEPTH],
  input  DCLineAddr_t              i_chk_line,
`ifdef DC_WB_FORWARD_EN
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic [127:0]             i_data [DEPTH],
  output logic [127:0]             o_data,
`endif
  output logic                     o_conflict
);

  logic [DEPTH-1:0] w_hit;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = i_valid[i] && (i_addr[i] == i_chk_line);
    end
  end

  assign o_conflict = |w_hit;

`ifdef DC_WB_FORWARD_EN
  localparam int PTR_W = $clog2(DEPTH);

  // Walk from oldest (head) to youngest; a later hit overrides an earlier one,
  // so duplicates resolve to the most recently pushed line.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hit[i_head + PTR_W'(k)]) begin
        o_data = i_data[i_head + PTR_W'(k)];
      end
    end
  end
`endif

endmodule

// File: rtl/dcache_wb_buffer.sv
// -----------------------------------------------------------------------------
// dcache_wb_buffer
//   Victim buffer for dirty DCache lines. Holds up to DEPTH evicted lines in a
//   circular FIFO and drains each one as a 4-beat, 32-bit AXI INCR write burst.
//   Reports to the refill path whether a requested line is still buffered.
//   Optional feature macro: DC_WB_FORWARD_EN adds chk_data (line forwarding).
//
// Ports
//   clk, rst           : clock; synchronous active-low reset
//   in_valid/in_ready  : line push handshake; in_addr (bits [3:0] ignored),
//                        in_data (word 0 in bits [31:0])
//   chk_addr           : refill address, compared on bits [31:4]
//   chk_conflict       : a valid entry matches chk_addr
//   chk_data           : (DC_WB_FORWARD_EN) youngest matching entry's data
//   empty              : nothing buffered and no burst outstanding
//   aw*, w*, b*        : AXI write address / data / response channels
// -----------------------------------------------------------------------------
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int         DEPTH  = 2,
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_addr,
  input  logic [127:0] in_data,
  input  logic [31:0]  chk_addr,
  output logic         chk_conflict,
`ifdef DC_WB_FORWARD_EN
  output logic [127:0] chk_data,
`endif
  output logic         empty,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  DCWbEntry_t         r_entries [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_beat;
  DCWbState_t         r_state;
  DCWbState_t         w_state_next;

  DCWbEntry_t         w_head_entry;
  logic               w_push;
  logic               w_pop;
  logic               w_beat_fire;
  logic [DEPTH-1:0]   w_valid;
  DCLineAddr_t        w_addr [DEPTH];
  logic               w_unused;

  assign in_ready     = (r_count != CNT_W'(DEPTH));
  assign w_push       = in_valid && in_ready;
  assign w_pop        = (r_state == B) && bvalid;
  assign w_beat_fire  = (r_state == W) && wready;
  assign w_head_entry = r_entries[r_head];

  // Response code is not acted on; low address bits select bytes inside a line.
  assign w_unused = ^{bresp, in_addr[3:0], chk_addr[3:0], w_head_entry.valid};

  // ---------------------------------------------------------------------------
  // FIFO storage, pointers and drain state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_beat  <= '0;
      r_state <= IDLE;
      // NOTE: only the valid bits are reset; address/data payload is never
      // read while invalid, so clearing the whole line array buys nothing.
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      r_state <= w_state_next;

      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1, addr: in_addr[31:4], data: in_data};
        r_tail            <= r_tail + PTR_W'(1);
      end

      // Head and tail only coincide when empty (no pop possible) or full
      // (push refused), so push and pop never touch the same entry.
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_beat_fire) begin
        r_beat <= r_beat + 2'd1;   // wraps back to 0 after beat 3
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM next state and channel handshakes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (r_state)
      IDLE: begin
        // A push on this edge starts the burst one cycle after it lands.
        if ((r_count != '0) || w_push) w_state_next = AW;
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) w_state_next = W;
      end
      W: begin
        wvalid = 1'b1;
        if (wready && (r_beat == 2'd3)) w_state_next = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign awid    = AXI_ID;
  assign awaddr  = {w_head_entry.addr, 4'b0000};
  assign awlen   = DC_WB_AWLEN;
  assign awsize  = DC_WB_AWSIZE;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = w_head_entry.data[{r_beat, 5'd0} +: 32];
  assign wstrb   = 4'hF;
  assign wlast   = (r_state == W) && (r_beat == 2'd3);
  assign empty   = (r_count == '0) && (r_state == IDLE);

  // ---------------------------------------------------------------------------
  // Refill conflict check
  // ---------------------------------------------------------------------------
`ifdef DC_WB_FORWARD_EN
  logic [127:0] w_data [DEPTH];
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_entries[i].valid;
      w_addr[i]  = r_entries[i].addr;
`ifdef DC_WB_FORWARD_EN
      w_data[i]  = r_entries[i].data;
`endif
    end
  end

  dc_wb_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .i_valid    (w_valid),
    .i_addr     (w_addr),
    .i_chk_line (chk_addr[31:4]),
`ifdef DC_WB_FORWARD_EN
    .i_head     (r_head),
    .i_data     (w_data),
    .o_data     (chk_data),
`endif
    .o_conflict (chk_conflict)
  );

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_wb_buffer
//   Self-checking bench for dcache_wb_buffer (DEPTH = 2). A cycle table drives
//   single-line drain, full-buffer refusal, push+pop in one cycle and W-channel
//   backpressure; hand-written sequences cover conflict lifetime, reset in the
//   middle of a burst and, with DC_WB_FORWARD_EN, youngest-entry forwarding.
// -----------------------------------------------------------------------------
module tb_dcache_wb_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_addr;
  logic [127:0] in_data;
  logic [31:0]  chk_addr;
  logic         chk_conflict;
`ifdef DC_WB_FORWARD_EN
  logic [127:0] chk_data;
`endif
  logic         empty;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  always #5 clk = ~clk;

  dcache_wb_buffer #(
    .DEPTH  (2),
    .AXI_ID (4'h1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .chk_addr     (chk_addr),
    .chk_conflict (chk_conflict),
`ifdef DC_WB_FORWARD_EN
    .chk_data     (chk_data),
`endif
    .empty        (empty),
    .awid         (awid),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awsize       (awsize),
    .awburst      (awburst),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready)
  );

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] D3 = 128'hB0000003_B0000002_B0000001_B0000000;
  localparam logic [127:0] D4 = 128'hC0000003_C0000002_C0000001_C0000000;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row = one clock cycle: inputs applied before the edge, outputs
  // expected in that same cycle.
  //   ctl = {in_valid, awready, wready, bvalid}
  //   exp = {awvalid, wvalid, wlast, bready, in_ready, empty, chk_conflict}
  typedef struct {
    logic [3:0]   ctl;
    logic [31:0]  ia;
    logic [127:0] id;
    logic [31:0]  ca;
    logic [6:0]   exp;
    logic [31:0]  aa;   // expected awaddr when awvalid
    logic [31:0]  wd;   // expected wdata when wvalid
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] ia,
                              input logic [127:0] id, input logic [31:0] ca,
                              input logic [6:0] exp, input logic [31:0] aa,
                              input logic [31:0] wd);
    vec_t v;
    v.ctl = ctl; v.ia = ia; v.id = id; v.ca = ca;
    v.exp = exp; v.aa = aa; v.wd = wd;
    return v;
  endfunction

  // Drive handshakes high and wait (bounded) until the DUT reaches the B phase.
  task automatic run_to_b(input string name);
    bit seen;
    seen    = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (bready) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_reach_b"}, 128'(seen), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;

    // ---------------- cycle table ----------------
    // single line, conflict on 0x8000_1234
    vecs.push_back(mk(4'b1110, 32'h8000_1230, D1, 32'h8000_1234, 7'b0000110, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0110, 32'h0, '0, 32'h8000_1234, 7'b1000101, 32'h8000_1230, 32'h0));
    vecs.push_back(mk(4'b0110, 32'h0, '0, 32'h8000_1234, 7'b0100101, 32'h0, 32'h1111_1111));
    vecs.push_back(mk(4'b0110, 32'h0, '0, 32'h8000_1234, 7'b0100101, 32'h0, 32'h2222_2222));
    vecs.push_back(mk(4'b0110, 32'h0, '0, 32'h8000_1234, 7'b0100101, 32'h0, 32'h3333_3333));
    vecs.push_back(mk(4'b0110, 32'h0, '0, 32'h8000_1234, 7'b0110101, 32'h0, 32'h4444_4444));
    vecs.push_back(mk(4'b0111, 32'h0, '0, 32'h8000_1234, 7'b0001101, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0110, 32'h0, '0, 32'h8000_1234, 7'b0000110, 32'h0, 32'h0));
    // full buffer with awready low, third push refused
    vecs.push_back(mk(4'b1000, 32'h100, D2, 32'h200, 7'b0000110, 32'h0, 32'h0));
    vecs.push_back(mk(4'b1000, 32'h200, D3, 32'h200, 7'b1000100, 32'h100, 32'h0));
    vecs.push_back(mk(4'b1000, 32'h300, '0, 32'h200, 7'b1000001, 32'h100, 32'h0));
    vecs.push_back(mk(4'b0100, 32'h0, '0, 32'h200, 7'b1000001, 32'h100, 32'h0));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0100001, 32'h0, 32'hA000_0000));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0100001, 32'h0, 32'hA000_0001));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0100001, 32'h0, 32'hA000_0002));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0110001, 32'h0, 32'hA000_0003));
    vecs.push_back(mk(4'b0001, 32'h0, '0, 32'h200, 7'b0001001, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h200, 7'b0000101, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0100, 32'h0, '0, 32'h200, 7'b1000101, 32'h200, 32'h0));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0100101, 32'h0, 32'hB000_0000));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0100101, 32'h0, 32'hB000_0001));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0100101, 32'h0, 32'hB000_0002));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h200, 7'b0110101, 32'h0, 32'hB000_0003));
    // push and pop in the same cycle, then backpressure 1,0,0,1,1,0,1
    vecs.push_back(mk(4'b1001, 32'h500, D4, 32'h500, 7'b0001100, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h500, 7'b0000101, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0100, 32'h0, '0, 32'h500, 7'b1000101, 32'h500, 32'h0));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h500, 7'b0100101, 32'h0, 32'hC000_0000));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h500, 7'b0100101, 32'h0, 32'hC000_0001));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h500, 7'b0100101, 32'h0, 32'hC000_0001));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h500, 7'b0100101, 32'h0, 32'hC000_0001));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h500, 7'b0100101, 32'h0, 32'hC000_0002));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h500, 7'b0110101, 32'h0, 32'hC000_0003));
    vecs.push_back(mk(4'b0010, 32'h0, '0, 32'h500, 7'b0110101, 32'h0, 32'hC000_0003));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h500, 7'b0001101, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0001, 32'h0, '0, 32'h500, 7'b0001101, 32'h0, 32'h0));
    vecs.push_back(mk(4'b0000, 32'h0, '0, 32'h500, 7'b0000110, 32'h0, 32'h0));

    // ---------------- reset ----------------
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; chk_addr = '0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_awvalid", 128'(awvalid), 128'd0);
    check("rst_wvalid",  128'(wvalid),  128'd0);
    check("rst_wlast",   128'(wlast),   128'd0);
    check("rst_bready",  128'(bready),  128'd0);
    check("rst_conflict",128'(chk_conflict), 128'd0);
    check("rst_in_ready",128'(in_ready), 128'd1);
    check("rst_empty",   128'(empty),   128'd1);
    check("const_fields", {awid, awlen, awsize, awburst, wstrb}, {4'h1, 8'd3, 3'b010, 2'b01, 4'hF});
    rst = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {in_valid, awready, wready, bvalid} = vecs[i].ctl;
      in_addr  = vecs[i].ia;
      in_data  = vecs[i].id;
      chk_addr = vecs[i].ca;
      #1;
      check($sformatf("v%0d_awvalid", i),  128'(awvalid),      128'(vecs[i].exp[6]));
      check($sformatf("v%0d_wvalid", i),   128'(wvalid),       128'(vecs[i].exp[5]));
      check($sformatf("v%0d_wlast", i),    128'(wlast),        128'(vecs[i].exp[4]));
      check($sformatf("v%0d_bready", i),   128'(bready),       128'(vecs[i].exp[3]));
      check($sformatf("v%0d_in_ready", i), 128'(in_ready),     128'(vecs[i].exp[2]));
      check($sformatf("v%0d_empty", i),    128'(empty),        128'(vecs[i].exp[1]));
      check($sformatf("v%0d_conflict", i), 128'(chk_conflict), 128'(vecs[i].exp[0]));
      if (vecs[i].exp[6]) check($sformatf("v%0d_awaddr", i), 128'(awaddr), 128'(vecs[i].aa));
      if (vecs[i].exp[5]) check($sformatf("v%0d_wdata", i),  128'(wdata),  128'(vecs[i].wd));
    end

    // ---------------- conflict lifetime ----------------
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h8000_0040; in_data = D1;
    chk_addr = 32'h8000_004C; awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    #1;
    check("cl_pre_push", 128'(chk_conflict), 128'd0);
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk_addr = 32'h8000_004C;
      #1;
      check($sformatf("cl_hit_c%0d", c), 128'(chk_conflict), 128'd1);
      chk_addr = 32'h8000_0050;
      #1;
      check($sformatf("cl_miss_c%0d", c), 128'(chk_conflict), 128'd0);
      chk_addr = 32'h8000_004C;
      if (bready) begin
        bvalid = 1'b1;
        done   = 1'b1;
        break;
      end
    end
    check("cl_reach_b", 128'(done), 128'd1);
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    check("cl_drop", 128'(chk_conflict), 128'd0);
    check("cl_empty", 128'(empty), 128'd1);

    // ---------------- reset mid-burst ----------------
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h8000_1230; in_data = D1;
    chk_addr = 32'h8000_1230; awready = 1'b1; wready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (wvalid && (wdata == 32'h3333_3333)) begin
        done = 1'b1;
        break;
      end
    end
    check("rmb_reach_beat2", 128'(done), 128'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmb_wvalid",   128'(wvalid),       128'd0);
    check("rmb_awvalid",  128'(awvalid),      128'd0);
    check("rmb_empty",    128'(empty),        128'd1);
    check("rmb_in_ready", 128'(in_ready),     128'd1);
    check("rmb_conflict", 128'(chk_conflict), 128'd0);
    @(negedge clk);
    #1;
    check("rmb_stays_idle", 128'(awvalid), 128'd0);

    // ---------------- recovery after reset ----------------
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h0000_0700; in_data = D2; chk_addr = 32'h0000_0708;
    run_to_b("rec");
    check("rec_conflict", 128'(chk_conflict), 128'd1);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    check("rec_empty", 128'(empty), 128'd1);

`ifdef DC_WB_FORWARD_EN
    // ---------------- forwarding, youngest duplicate wins ----------------
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    in_valid = 1'b1; in_addr = 32'h40; in_data = D3;
    @(negedge clk);
    in_addr = 32'h40; in_data = D4;
    @(negedge clk);
    in_valid = 1'b0; chk_addr = 32'h40;
    #1;
    check("fw_conflict", 128'(chk_conflict), 128'd1);
    check("fw_data_b", chk_data, D4);
    run_to_b("fw1");
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    check("fw_after_pop_conflict", 128'(chk_conflict), 128'd1);
    check("fw_after_pop_data", chk_data, D4);
    run_to_b("fw2");
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    check("fw_final_empty", 128'(empty), 128'd1);
    check("fw_final_conflict", 128'(chk_conflict), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
# dcache_wb_buffer

Write-back victim buffer between the DCache and the AXI write channel. It captures dirty lines that the DCache evicts on a replace or a writeback-clear, together with their line addresses. It drains each line to memory as one 4-beat, 32-bit AXI INCR write burst. It also tells the DCache refill path when a requested line is still waiting in the buffer, so stale memory is never read.

## Interface
- `DEPTH`, default 2: number of buffered 128-bit lines; a power of 2, at least 2.
- `AXI_ID`, default 4'h1: constant driven on `awid`.
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-low reset; state is cleared on a `clk` edge where `rst == 0`.
- `in_valid`  in  1: DCache presents a dirty line (driven from `dirt_valid`).
- `in_ready`  out  1: buffer can accept a line.
- `in_addr`  in  32: line address; bits [3:0] are ignored.
- `in_data`  in  128: line data; bits [31:0] hold word 0.
- `chk_addr`  in  32: refill address to check; compared on bits [31:4].
- `chk_conflict`  out  1: a valid entry matches `chk_addr`.
- `chk_data`  out  128: youngest matching entry's data; present only with `DC_WB_FORWARD_EN`.
- `empty`  out  1: no valid entries and no burst outstanding.
- `awid`  out  4: write ID.
- `awaddr`  out  32: burst address.
- `awlen`  out  8: beats minus one.
- `awsize`  out  3: bytes per beat.
- `awburst`  out  2: burst type.
- `awvalid`  out  1: write address valid.
- `awready`  in  1: write address ready.
- `wdata`  out  32: write data beat.
- `wstrb`  out  4: byte strobes.
- `wlast`  out  1: last beat of the burst.
- `wvalid`  out  1: write data valid.
- `wready`  in  1: write data ready.
- `bresp`  in  2: write response; ignored.
- `bvalid`  in  1: write response valid.
- `bready`  out  1: write response ready.

## Operation
- **Storage:** circular FIFO of `DEPTH` entries, each {valid, addr[31:4], data[127:0]}, with head/tail pointers and a count of width clog2(`DEPTH`)+1.
- **Push:**
  - `in_ready = (count != DEPTH)`.
  - A push is `in_valid & in_ready` on an edge; it writes the entry at the tail.
  - A full buffer refuses pushes, even when a pop happens in the same cycle.
- **Drain FSM:**
  - IDLE: leaves for AW when count > 0.
  - AW: holds `awvalid = 1`; leaves for W on `awready`.
  - W: sends beats 0..3 from the head entry, beat k = data[32k+31:32k]. A 2-bit beat counter advances on each `wvalid & wready`. After the beat-3 handshake it goes to B.
  - B: holds `bready = 1`. On `bvalid` it pops the head, clears its valid bit and returns to IDLE.
- **Burst fields:** `awaddr = {addr, 4'b0}`, `awlen = 3`, `awsize = 3'b010`, `awburst = 2'b01`, `wstrb = 4'hF`, `wlast` = (beat counter == 3).
- **Conflict check:**
  - Combinational compare of `chk_addr[31:4]` against every valid entry, including the head entry while its burst is in flight. The head stays valid until B completes.
  - Duplicate line addresses are legal; both entries are kept and drained in order.
- **Simultaneous push and pop (count < DEPTH):** both take effect and the count is unchanged.
- **Pointer arithmetic:** pointers wrap modulo `DEPTH`.

## Timing
- **Reset values:** `awvalid`, `wvalid`, `wlast`, `bready`, `chk_conflict` = 0; `in_ready` = 1; `empty` = 1; pointers and count = 0; all entries invalid; FSM in IDLE.
- **Push to request:** a push at edge N with FSM in IDLE gives `awvalid = 1` in cycle N+1. The entry is visible to the conflict check from cycle N+1.
- **Beat timing:** `wvalid` first rises in the cycle after the AW handshake. With `wready` held high, one beat transfers per cycle.
- **Handshake holds:**
  - `awvalid` stays high until `awready`; `awaddr` is stable throughout.
  - `wvalid`, `wdata` and `wlast` stay stable until `wready`.
- **Pop:** `bvalid` at edge M pops the head. `chk_conflict` for that line drops in cycle M+1, and `in_ready` rises in cycle M+1 if the buffer was full.
- **`empty`:** `empty = (count == 0) & (state == IDLE)`.
- **Reset mid-burst:** all state is dropped immediately and the burst is abandoned. The interconnect is reset together with this block.

## Configuration
- `DC_WB_FORWARD_EN` defined:
  - `chk_data` exists and carries the youngest matching entry's data (tail-relative priority).
  - The DCache refill path takes this line and skips the AXI read.
- `DC_WB_FORWARD_EN` undefined:
  - The `chk_data` port is absent.
  - The DCache must stall the refill while `chk_conflict = 1`, until the matching entry drains.

## Structure
- Shared DCache package holds:
  - the entry struct `DCWbEntry_t`;
  - line-address typedef `DCLineAddr_t` (32-4 bits);
  - FSM enum `{IDLE, AW, W, B}`;
  - constants `DC_WB_AWLEN = 3`, `DC_WB_AWSIZE = 3'b010`, `AXI_BURST_INCR = 2'b01`.
- One sub-module, `dc_wb_match`: the `DEPTH`-way address comparator plus youngest-match priority select, producing `chk_conflict` and `chk_data`.

## Test plan
- **Single line:** push addr 0x8000_1230, data 0x4444_4444_3333_3333_2222_2222_1111_1111, with `awready`/`wready` held 1 and `bvalid` one cycle after `wlast`.
  - `awaddr = 0x8000_1230`, `awlen = 3`.
  - Beats 0x1111_1111, 0x2222_2222, 0x3333_3333, 0x4444_4444; `wlast` on the 4th beat only.
  - `empty` returns to 1.
- **Full buffer:** push 0x100 and 0x200 with `awready` held 0.
  - `in_ready = 0` after the 2nd push; a 3rd push is refused.
  - `in_ready` returns to 1 the cycle after the first `bvalid`.
- **Conflict lifetime:** push 0x8000_0040; set `chk_addr = 0x8000_004C`.
  - `chk_conflict = 1` from the cycle after the push through the burst.
  - `chk_conflict` drops the cycle after `bvalid`; `chk_addr = 0x8000_0050` gives 0 throughout.
- **Forward (macro on):** push 0x40 with data A, then 0x40 with data B.
  - `chk_addr = 0x40` gives `chk_data = B`.
  - After the first pop, `chk_data` is still B.
- **Backpressure:** toggle `wready` 1,0,0,1,1,0,1.
  - Exactly 4 beats transfer, in order; `wdata`/`wlast` hold while stalled.
- **Reset mid-burst:** `rst = 0` during beat 2.
  - Next cycle: `wvalid = 0`, `awvalid = 0`, `empty = 1`, `in_ready = 1`, `chk_conflict = 0`.
